// File: rtl/cix32_prefetch_queue.sv
// CIX-32 instruction prefetch queue: fetches aligned words into a circular byte
// buffer and exposes a registered window of upcoming instruction bytes to the decoder.
module cix32_prefetch_queue #(
  parameter int unsigned QUEUE_BYTES = 16,
  parameter int unsigned WIN_BYTES   = 8,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [31:0]                    mem_addr,
  output logic                           mem_re,
  input  logic [31:0]                    mem_rdata,
  input  logic                           mem_ready,
  input  logic                           flush,
  input  logic [31:0]                    flush_pc,
  output logic [8*WIN_BYTES-1:0]         win_data,
  output logic [$clog2(WIN_BYTES+1)-1:0] win_count,
  output logic [31:0]                    win_pc,
  input  logic                           consume,
  input  logic [$clog2(WIN_BYTES+1)-1:0] consume_len,
  output logic                           consume_err
);
  localparam int unsigned PTR_W = $clog2(QUEUE_BYTES);
  localparam int unsigned OCC_W = $clog2(QUEUE_BYTES + 1);
  localparam int unsigned CNT_W = $clog2(WIN_BYTES + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             buf_q [QUEUE_BYTES];
  logic [7:0]             buf_d [QUEUE_BYTES];
  logic [PTR_W-1:0]       rd_q, rd_d, wr_q, wr_d;
  logic [OCC_W-1:0]       occ_q, occ_d, free_q, free_d;
  logic [31:0]            fetch_q, fetch_d;
  logic [1:0]             skip_q, skip_d;
  logic [31:0]            addr_d, pc_d;
  logic                   err_d;
  logic [2:0]             wr_cnt;
  logic [CNT_W-1:0]       cons_cnt, win_count_d;
  logic [8*WIN_BYTES-1:0] win_data_d;

  assign free_q = OCC_W'(QUEUE_BYTES) - occ_q;
  assign free_d = OCC_W'(QUEUE_BYTES) - occ_d;

  // Next-state: flush wins over data and consume; skip_q drops the leading bytes of a redirected word.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    occ_d    = occ_q;
    fetch_d  = fetch_q;
    skip_d   = skip_q;
    addr_d   = mem_addr;
    pc_d     = win_pc;
    err_d    = 1'b0;
    wr_cnt   = '0;
    cons_cnt = '0;
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      occ_d   = '0;
      pc_d    = flush_pc;
      fetch_d = {flush_pc[31:2], 2'b00};
      skip_d  = flush_pc[1:0];
      state_d = (state_q != IDLE && !mem_ready) ? DISCARD : FETCH;
    end else begin
      if (state_q == FETCH && mem_ready) begin
        wr_cnt = 3'(3'd4 - 3'(skip_q));
        for (int unsigned k = 0; k < 4; k++) begin
          if (k >= 32'(skip_q))
            buf_d[PTR_W'(wr_q + PTR_W'(k) - PTR_W'(skip_q))] = mem_rdata[8*k +: 8];
        end
        wr_d    = wr_q + PTR_W'(wr_cnt);
        fetch_d = fetch_q + 32'd4;
        skip_d  = '0;
      end
      if (consume) begin
        if (consume_len == '0 || consume_len > win_count) begin
          err_d = 1'b1;
        end else begin
          cons_cnt = consume_len;
          rd_d     = rd_q + PTR_W'(consume_len);
          pc_d     = win_pc + 32'(consume_len);
        end
      end
      occ_d = occ_q + OCC_W'(wr_cnt) - OCC_W'(cons_cnt);
      case (state_q)
        IDLE:    if (free_q >= OCC_W'(4)) state_d = FETCH;
        FETCH:   if (mem_ready) state_d = (free_d >= OCC_W'(4)) ? FETCH : IDLE;
        DISCARD: if (mem_ready) state_d = FETCH;
        default: state_d = IDLE;
      endcase
    end
    // DISCARD keeps the stale request address on the bus until it completes.
    if (state_d == FETCH) addr_d = fetch_d;
    win_count_d = (occ_d > OCC_W'(WIN_BYTES)) ? CNT_W'(WIN_BYTES) : CNT_W'(occ_d);
    for (int unsigned i = 0; i < WIN_BYTES; i++) begin
      win_data_d[8*i +: 8] = (CNT_W'(i) < win_count_d) ? buf_d[PTR_W'(rd_d + PTR_W'(i))] : 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_q        <= '0;
      wr_q        <= '0;
      occ_q       <= '0;
      fetch_q     <= {RESET_PC[31:2], 2'b00};
      skip_q      <= RESET_PC[1:0];
      mem_re      <= 1'b0;
      mem_addr    <= '0;
      win_pc      <= RESET_PC;
      win_count   <= '0;
      win_data    <= '0;
      consume_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      occ_q       <= occ_d;
      fetch_q     <= fetch_d;
      skip_q      <= skip_d;
      mem_re      <= (state_d != IDLE);
      mem_addr    <= addr_d;
      win_pc      <= pc_d;
      win_count   <= win_count_d;
      win_data    <= win_data_d;
      consume_err <= err_d;
    end
  end

  // Byte storage needs no reset: only bytes below the occupancy are ever exposed.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end
endmodule

// File: tb/tb_cix32_prefetch_queue.sv
// Bench for cix32_prefetch_queue: directed scenarios plus random traffic checked
// against an address-level model of the instruction byte stream.
module tb_cix32_prefetch_queue;
  localparam int unsigned QB  = 16;
  localparam int unsigned WB  = 8;
  localparam logic [31:0] RPC = 32'h0;
  localparam int unsigned CW  = $clog2(WB + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   mem_addr, mem_rdata, win_pc;
  logic [31:0]   flush_pc = '0;
  logic          mem_re, consume_err;
  logic          mem_ready = 1'b0, flush = 1'b0, consume = 1'b0;
  logic [8*WB-1:0] win_data;
  logic [CW-1:0] win_count;
  logic [CW-1:0] consume_len = '0;

  always #5 clk = ~clk;

  cix32_prefetch_queue #(.QUEUE_BYTES(QB), .WIN_BYTES(WB), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .flush(flush), .flush_pc(flush_pc), .win_data(win_data),
    .win_count(win_count), .win_pc(win_pc), .consume(consume), .consume_len(consume_len),
    .consume_err(consume_err)
  );

  // Memory image: byte value is a fixed function of its address.
  function automatic logic [7:0] mbyte(input logic [31:0] a);
    return 8'((a + 32'd1) * 32'd17) ^ a[15:8];
  endfunction

  assign mem_rdata = {mbyte(mem_addr + 32'd3), mbyte(mem_addr + 32'd2),
                      mbyte(mem_addr + 32'd1), mbyte(mem_addr)};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: linear byte stream starting at m_pc with m_occ bytes buffered.
  logic [31:0] m_pc, m_fetch;
  logic [1:0]  m_skip;
  logic        m_drop, m_err;
  int          m_occ, n_accept;

  function automatic int m_count();
    return (m_occ > int'(WB)) ? int'(WB) : m_occ;
  endfunction

  task automatic check_outputs();
    int ec;
    logic [8*WB-1:0] ed;
    ec = m_count();
    ed = '0;
    for (int i = 0; i < ec; i++) ed[8*i +: 8] = mbyte(m_pc + 32'(i));
    chk("win_count", 64'(win_count), 64'(ec));
    chk("win_pc", 64'(win_pc), 64'(m_pc));
    chk("win_data", 64'(win_data), 64'(ed));
    chk("consume_err", 64'(consume_err), 64'(m_err));
    if (m_occ > int'(QB) - 4) chk("re_when_full", 64'(mem_re), 64'(0));
  endtask

  task automatic step();
    logic        prev_hold;
    logic [31:0] prev_addr;
    int          wr, cn;
    prev_hold = mem_re && !mem_ready;
    prev_addr = mem_addr;
    if (mem_re) chk("addr_align", 64'(mem_addr[1:0]), 64'(0));
    m_err = 1'b0;
    if (flush) begin
      m_drop  = mem_re && !mem_ready;
      m_pc    = flush_pc;
      m_occ   = 0;
      m_fetch = flush_pc & ~32'h3;
      m_skip  = 2'(flush_pc & 32'h3);
    end else begin
      wr = 0;
      cn = 0;
      if (mem_re && mem_ready) begin
        if (m_drop) begin
          m_drop = 1'b0;
        end else begin
          chk("fetch_addr", 64'(mem_addr), 64'(m_fetch));
          wr      = 4 - int'(m_skip);
          m_fetch = m_fetch + 32'd4;
          m_skip  = 2'd0;
          n_accept++;
        end
      end
      if (consume) begin
        if (consume_len == '0 || int'(consume_len) > m_count()) begin
          m_err = 1'b1;
        end else begin
          cn   = int'(consume_len);
          m_pc = m_pc + 32'(cn);
        end
      end
      m_occ = m_occ + wr - cn;
    end
    @(posedge clk);
    #1;
    if (prev_hold) begin
      chk("req_held", 64'(mem_re), 64'(1));
      chk("addr_held", 64'(mem_addr), 64'(prev_addr));
    end
    check_outputs();
  endtask

  task automatic cyc(input logic f, input logic [31:0] fpc, input logic c, input int len,
                     input logic rdy);
    flush       = f;
    flush_pc    = fpc;
    consume     = c;
    consume_len = CW'(len);
    mem_ready   = rdy;
    step();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    flush       = 1'b0;
    consume     = 1'b0;
    consume_len = '0;
    mem_ready   = 1'b0;
    m_pc        = RPC;
    m_occ       = 0;
    m_fetch     = RPC & ~32'h3;
    m_skip      = 2'(RPC & 32'h3);
    m_drop      = 1'b0;
    m_err       = 1'b0;
    n_accept    = 0;
    #1;
    chk("rst_mem_re", 64'(mem_re), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_win_count", 64'(win_count), 64'(0));
    chk("rst_win_data", 64'(win_data), 64'(0));
    chk("rst_win_pc", 64'(win_pc), 64'(RPC));
    chk("rst_consume_err", 64'(consume_err), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int len, ec;
    do_reset();

    // First fetch after reset with one wait state
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t1_re", 64'(mem_re), 64'(1));
    chk("t1_addr", 64'(mem_addr), 64'(0));
    cyc(0, 0, 0, 0, 1);
    chk("t1_count", 64'(win_count), 64'(4));
    chk("t1_data", 64'(win_data[31:0]), 64'(32'h4433_2211));
    chk("t1_pc", 64'(win_pc), 64'(0));

    // Linear fill stops at a full queue
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1);
    chk("t2_fetches", 64'(n_accept), 64'(4));
    chk("t2_re", 64'(mem_re), 64'(0));
    chk("t2_count", 64'(win_count), 64'(8));

    // Consume and write in the same cycle
    cyc(0, 0, 1, 4, 0);
    for (int i = 0; i < 6 && !mem_re; i++) cyc(0, 0, 0, 0, 0);
    chk("t3_re", 64'(mem_re), 64'(1));
    cyc(0, 0, 1, 3, 1);
    chk("t3_pc", 64'(win_pc), 64'(7));
    cyc(0, 0, 1, 8, 0);
    chk("t3_count", 64'(win_count), 64'(5));

    // Flush while a request is outstanding
    cyc(1, 32'h20, 0, 0, 1);
    chk("t4_req20", 64'(mem_addr), 64'(32'h20));
    cyc(1, 32'h103, 0, 0, 0);
    chk("t4_hold", 64'(mem_addr), 64'(32'h20));
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t4_addr", 64'(mem_addr), 64'(32'h100));
    chk("t4_empty", 64'(win_count), 64'(0));
    cyc(0, 0, 0, 0, 1);
    chk("t4_count", 64'(win_count), 64'(1));
    chk("t4_pc", 64'(win_pc), 64'(32'h103));

    // Over-long consume is rejected
    cyc(1, 32'h101, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t5_count0", 64'(win_count), 64'(3));
    cyc(0, 0, 1, 5, 0);
    chk("t5_err", 64'(consume_err), 64'(1));
    chk("t5_pc", 64'(win_pc), 64'(32'h101));
    chk("t5_count", 64'(win_count), 64'(3));
    cyc(0, 0, 0, 0, 0);
    chk("t5_pulse", 64'(consume_err), 64'(0));

    // Reset while a request is in flight
    chk("t6_pre", 64'(mem_re), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("t6_re", 64'(mem_re), 64'(0));
    chk("t6_count", 64'(win_count), 64'(0));
    do_reset();
    for (int i = 0; i < 6 && !mem_re; i++) cyc(0, 0, 0, 0, 0);
    chk("t6_addr", 64'(mem_addr), 64'(RPC & ~32'h3));
    cyc(0, 0, 0, 0, 1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      flush    = ($urandom_range(0, 39) == 0);
      flush_pc = 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 7) == 0) flush_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      consume = ($urandom_range(0, 1) == 1);
      ec = m_count();
      if (ec == 0 || $urandom_range(0, 4) == 0) len = int'($urandom_range(0, WB + 1));
      else len = int'($urandom_range(1, ec));
      consume_len = CW'(len);
      mem_ready   = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
